sync_fifo: RTL and testbench

- Single-clock first-in/first-out buffer with show-ahead read data and registered full/empty flags.
- Sits between a producer and a consumer that share one clock domain; typical use is streaming data words with `i_rd` tied to `~o_rempty` for drain-as-available.
- Storage is 2**ASIZE words of DSIZE bits, addressed by binary pointers that carry one extra wrap bit.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_if.sv | 39 +++
 rtl/sync_fifo_mem.sv | 35 +++
 rtl/sync_fifo.sv | 82 ++++++++
 tb/tb_sync_fifo.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared constants and types for the single-clock FIFO.
//   FIFO_DSIZE : default data word width in bits
//   FIFO_ASIZE : default address width (depth = 2**FIFO_ASIZE)
//   FIFO_DEPTH : derived number of storage words
//   ptr_t      : read/write pointer, one wrap bit wider than the address
package sync_fifo_pkg;

  localparam int FIFO_DSIZE = 16;
  localparam int FIFO_ASIZE = 8;
  localparam int FIFO_DEPTH = 2 ** FIFO_ASIZE;

  typedef logic [FIFO_ASIZE:0] ptr_t;

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if
// Producer/consumer handshake bundle for sync_fifo.
//   i_wr, i_wdata : write request and data (producer -> FIFO)
//   o_wfull       : FIFO full (FIFO -> producer)
//   i_rd          : pop request (consumer -> FIFO)
//   o_rdata       : show-ahead head-of-FIFO word (FIFO -> consumer)
//   o_rempty      : FIFO empty (FIFO -> consumer)
//   o_level       : occupancy, present only with SYNC_FIFO_LEVEL_EN defined
// Modports: master = producer/consumer side, slave = FIFO side.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int ASIZE = FIFO_ASIZE
);

  logic             i_wr;
  logic [DSIZE-1:0] i_wdata;
  logic             o_wfull;
  logic             i_rd;
  logic [DSIZE-1:0] o_rdata;
  logic             o_rempty;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [ASIZE:0]   o_level;
`endif

`ifdef SYNC_FIFO_LEVEL_EN
  modport master (output i_wr, i_wdata, i_rd,
                  input  o_wfull, o_rdata, o_rempty, o_level);
  modport slave  (input  i_wr, i_wdata, i_rd,
                  output o_wfull, o_rdata, o_rempty, o_level);
`else
  modport master (output i_wr, i_wdata, i_rd,
                  input  o_wfull, o_rdata, o_rempty);
  modport slave  (input  i_wr, i_wdata, i_rd,
                  output o_wfull, o_rdata, o_rempty);
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
// 2**ASIZE x DSIZE storage array for sync_fifo.
//   clk   : write clock
//   we    : write enable, sampled on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data (mem[raddr])
// Contents are never reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int ASIZE = FIFO_ASIZE
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [0:(2**ASIZE)-1];

  // Synchronous write port; the array has no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with show-ahead read data and registered full/empty
// flags. Binary pointers carry one extra wrap bit so full and empty can be
// told apart when the address bits match.
//   i_clk   : clock, all state updates on the rising edge
//   i_rst_n : asynchronous active-low reset (pointers and flags only)
//   bus     : sync_fifo_if.slave handshake bundle (i_wr, i_wdata, o_wfull,
//             i_rd, o_rdata, o_rempty, and o_level when enabled)
// Optional feature: define SYNC_FIFO_LEVEL_EN to add the registered
// occupancy output o_level = wptr - rptr.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int ASIZE = FIFO_ASIZE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sync_fifo_if.slave  bus
);

  logic [ASIZE:0] wptr, rptr;
  logic [ASIZE:0] wptr_next, rptr_next;
  logic           wr_en, rd_en;
  logic           rempty_q, wfull_q;

  // A write is gated only by full, so a same-cycle read never lets a write
  // into a full FIFO; likewise a read is gated only by empty.
  assign wr_en = bus.i_wr & ~wfull_q;
  assign rd_en = bus.i_rd & ~rempty_q;

  assign wptr_next = wptr + {{ASIZE{1'b0}}, wr_en};
  assign rptr_next = rptr + {{ASIZE{1'b0}}, rd_en};

  // Flags are computed from the next-state pointers so they change on the
  // same edge that moves the pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      rempty_q <= 1'b1;
      wfull_q  <= 1'b0;
    end else begin
      wptr     <= wptr_next;
      rptr     <= rptr_next;
      rempty_q <= (rptr_next == wptr_next);
      wfull_q  <= (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                  (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);
    end
  end

`ifdef SYNC_FIFO_LEVEL_EN
  logic [ASIZE:0] level_q;

  // Occupancy; wrap-bit arithmetic gives 0..2**ASIZE without extra logic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= wptr_next - rptr_next;
    end
  end

  assign bus.o_level = level_q;
`endif

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (i_clk),
    .we    (wr_en),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (bus.i_wdata),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (bus.o_rdata)
  );

  assign bus.o_rempty = rempty_q;
  assign bus.o_wfull  = wfull_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
// Self-checking bench for sync_fifo: a directed vector table for the
// single-word and empty-boundary cases, then streaming, fill/drain,
// full-boundary, wrap-around and asynchronous reset sequences. A queue
// scoreboard tracks expected words and occupancy.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_if #(.DSIZE(FIFO_DSIZE), .ASIZE(FIFO_ASIZE)) bus();

  sync_fifo #(
    .DSIZE (FIFO_DSIZE),
    .ASIZE (FIFO_ASIZE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int              nChecks  = 0;
  int              nFails   = 0;
  int              modelCnt = 0;
  logic [15:0]     expQ[$];

  typedef struct {
    logic        wr;
    logic [15:0] wdata;
    logic        rd;
    logic        expEmpty;
    logic        chkData;
    logic [15:0] expData;
  } vec_t;

  vec_t vecs[9];

  task automatic checkValue(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare flags and the
  // popped word against the scoreboard, then advance the model.
  task automatic applyStimulus(input logic wr, input logic [15:0] wd,
                               input logic rd, input logic drain);
    logic rdEff, wrOk, rdOk;
    @(negedge clk);
    rdEff       = drain ? ~bus.o_rempty : rd;
    bus.i_wr    = wr;
    bus.i_wdata = wd;
    bus.i_rd    = rdEff;
    checkValue("rempty", 32'(bus.o_rempty), 32'(modelCnt == 0));
    checkValue("wfull",  32'(bus.o_wfull),  32'(modelCnt == DEPTH));
`ifdef SYNC_FIFO_LEVEL_EN
    checkValue("level",  32'(bus.o_level),  32'(modelCnt));
`endif
    wrOk = wr && (modelCnt < DEPTH);
    rdOk = rdEff && (modelCnt > 0);
    if (rdOk) begin
      checkValue("rdata", 32'(bus.o_rdata), 32'(expQ[0]));
      void'(expQ.pop_front());
    end
    if (wrOk) expQ.push_back(wd);
    modelCnt = modelCnt + int'(wrOk) - int'(rdOk);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue($sformatf("vec%0d empty", idx), 32'(bus.o_rempty), 32'(v.expEmpty));
    if (v.chkData)
      checkValue($sformatf("vec%0d rdata", idx), 32'(bus.o_rdata), 32'(v.expData));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            wr    wdata     rd    empty chk  data
    vecs[0] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000}; // read at empty
    vecs[1] = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000}; // single write
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234}; // visible, pop
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000}; // empty again
    vecs[4] = '{1'b1, 16'hA5A5, 1'b1, 1'b1, 1'b0, 16'h0000}; // wr+rd at empty
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5}; // word stored
    vecs[6] = '{1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b1, 16'hA5A5}; // wr+rd mid
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5A5A};
    vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};

    bus.i_wr    = 1'b0;
    bus.i_wdata = '0;
    bus.i_rd    = 1'b0;

    // Reset held for 100 ns
    #98;
    checkValue("reset rempty", 32'(bus.o_rempty), 32'd1);
    checkValue("reset wfull",  32'(bus.o_wfull),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].wdata, vecs[i].rd, 1'b0);
      checkOutput(vecs[i], i);
    end

    // Streaming with drain-as-available
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b1, 16'(16'h1235 + i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);

    // Fill to full, then a write that must be dropped
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
    // Write and read together at full: only the read happens
    applyStimulus(1'b1, 16'hCAFE, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 4 && modelCnt > 0; i++)
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    // Occupancy held at 3 across pointer wrap
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
    for (int i = 0; i < 600; i++)
      applyStimulus(1'b1, 16'(16'h4003 + i), 1'b1, 1'b0);

    // Asynchronous reset mid-stream
    @(negedge clk);
    bus.i_wr = 1'b0;
    bus.i_rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("async rempty", 32'(bus.o_rempty), 32'd1);
    checkValue("async wfull",  32'(bus.o_wfull),  32'd0);
    expQ.delete();
    modelCnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
